srio_nwr_scheduler: RTL and testbench

Sits in the `clk_srio` domain between two 64-bit packet sources and the SRIO NWRITE initiator. Channel 0 is the UDP-to-SRIO stream and channel 1 is a local source. The block arbitrates between the sources at packet boundaries and splits each packet into NWRITE bursts of at most 256 bytes. For every burst it issues a header (address, byte count, channel), then passes the burst's data beats straight through with a per-burst `last`.

---
 rtl/srio_nwr_scheduler.sv | 246 ++++++++++++++++++++++++
 tb/tb_srio_nwr_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/srio_nwr_scheduler.sv
// rtl/srio_nwr_scheduler.sv - two-source NWRITE burst scheduler for the clk_srio domain
//
// Arbitrates between ch0 (UDP-to-SRIO stream) and ch1 (local source) at packet
// boundaries. Each packet is cut into NWRITE bursts of at most MAX_BURST_BYTES.
// Every burst is announced by a registered header. The burst's beats then flow
// through combinationally, with dat_last_out marking the end of each burst.
//
// Optional feature macro: NWR_SCHED_RR_EN
//   defined   : round-robin arbitration between the two channels
//   undefined : strict priority, ch0 wins; no priority pointer is built
//
// Ports:
//   clk_srio, reset_srio_n        clock, asynchronous active-low reset
//   chN_data_in/keep_in           source beat payload and byte enables (N = 0, 1)
//   chN_valid_in/ready_out        source beat handshake
//   chN_first_in/last_in          packet delimiters
//   chN_length_in                 packet byte count, sampled with the first beat
//   chN_base_addr_in              target address of the packet's first byte
//   hdr_valid_out/hdr_ready_in    burst header handshake
//   hdr_addr_out/size_out/ch_out  burst start address, byte count, channel
//   dat_data_out/keep_out         burst payload (pass-through of granted channel)
//   dat_valid_out/ready_in        burst data handshake
//   dat_last_out                  last beat of the current burst
//   len_err_out                   sticky length/last mismatch, cleared by reset only
module srio_nwr_scheduler #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 34,
  parameter int MAX_BURST_BYTES = 256
) (
  input  logic                    clk_srio,
  input  logic                    reset_srio_n,
  input  logic [DATA_WIDTH-1:0]   ch0_data_in,
  input  logic                    ch0_valid_in,
  input  logic                    ch0_first_in,
  input  logic                    ch0_last_in,
  input  logic [DATA_WIDTH/8-1:0] ch0_keep_in,
  input  logic [15:0]             ch0_length_in,
  input  logic [ADDR_WIDTH-1:0]   ch0_base_addr_in,
  output logic                    ch0_ready_out,
  input  logic [DATA_WIDTH-1:0]   ch1_data_in,
  input  logic                    ch1_valid_in,
  input  logic                    ch1_first_in,
  input  logic                    ch1_last_in,
  input  logic [DATA_WIDTH/8-1:0] ch1_keep_in,
  input  logic [15:0]             ch1_length_in,
  input  logic [ADDR_WIDTH-1:0]   ch1_base_addr_in,
  output logic                    ch1_ready_out,
  output logic                    hdr_valid_out,
  input  logic                    hdr_ready_in,
  output logic [ADDR_WIDTH-1:0]   hdr_addr_out,
  output logic [8:0]              hdr_size_out,
  output logic                    hdr_ch_out,
  output logic [DATA_WIDTH-1:0]   dat_data_out,
  output logic                    dat_valid_out,
  output logic [DATA_WIDTH/8-1:0] dat_keep_out,
  output logic                    dat_last_out,
  input  logic                    dat_ready_in,
  output logic                    len_err_out
);

  localparam int KEEP_W    = DATA_WIDTH / 8;
  localparam int MAX_BEATS = MAX_BURST_BYTES / KEEP_W;
  localparam int CNT_W     = $clog2(MAX_BEATS + 1);
  localparam logic [15:0] MAX_BYTES_16 = 16'(MAX_BURST_BYTES);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DRAIN} state_t;

  state_t                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic [15:0]           remain_q, remain_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            size_q, size_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic                  len_err_q, len_err_d;

  // Bytes of the next burst: whatever is left, capped at one NWRITE payload.
  function automatic logic [8:0] burst_size(input logic [15:0] bytes);
    if (bytes > MAX_BYTES_16) burst_size = 9'(MAX_BURST_BYTES);
    else                      burst_size = bytes[8:0];
  endfunction

  // Granted-channel view, used by DATA and DRAIN.
  logic                  g_valid, g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic [KEEP_W-1:0]     g_keep;

  assign g_valid = gnt_q ? ch1_valid_in : ch0_valid_in;
  assign g_last  = gnt_q ? ch1_last_in  : ch0_last_in;
  assign g_data  = gnt_q ? ch1_data_in  : ch0_data_in;
  assign g_keep  = gnt_q ? ch1_keep_in  : ch0_keep_in;

  // Arbitration between packet-start requests.
  logic                  req0, req1, pick1;
  logic [15:0]           sel_len;
  logic [ADDR_WIDTH-1:0] sel_addr;

  assign req0 = ch0_valid_in && ch0_first_in;
  assign req1 = ch1_valid_in && ch1_first_in;

`ifdef NWR_SCHED_RR_EN
  // prio_q names the channel that wins a tie; it toggles once per finished packet.
  logic prio_q, prio_d;
  assign pick1 = req1 && (!req0 || prio_q);
`else
  assign pick1 = req1 && !req0;
`endif

  assign sel_len  = pick1 ? ch1_length_in    : ch0_length_in;
  assign sel_addr = pick1 ? ch1_base_addr_in : ch0_base_addr_in;

  // Index of the final beat of the current burst: ceil(size/KEEP_W) - 1.
  logic [15:0]      burst_beats;
  logic [CNT_W-1:0] last_idx;
  logic [15:0]      remain_after;
  logic             beat_fire, at_burst_end;

  assign burst_beats  = (16'(size_q) + 16'(KEEP_W - 1)) / 16'(KEEP_W);
  assign last_idx     = CNT_W'(burst_beats - 16'd1);
  assign remain_after = remain_q - 16'(size_q);
  assign beat_fire    = (state_q == DATA) && g_valid && dat_ready_in;
  assign at_burst_end = (beat_cnt_q == last_idx);

  // Header fields come straight from registers, so they hold while stalled.
  assign hdr_addr_out = addr_q;
  assign hdr_size_out = size_q;
  assign hdr_ch_out   = gnt_q;
  assign len_err_out  = len_err_q;

  always_ff @(posedge clk_srio or negedge reset_srio_n) begin
    if (!reset_srio_n) begin
      state_q    <= IDLE;
      gnt_q      <= 1'b0;
      remain_q   <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
`ifdef NWR_SCHED_RR_EN
      prio_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      remain_q   <= remain_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      beat_cnt_q <= beat_cnt_d;
      len_err_q  <= len_err_d;
`ifdef NWR_SCHED_RR_EN
      prio_q     <= prio_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    remain_d      = remain_q;
    addr_d        = addr_q;
    size_d        = size_q;
    beat_cnt_d    = beat_cnt_q;
    len_err_d     = len_err_q;
    hdr_valid_out = 1'b0;
    dat_valid_out = 1'b0;
    dat_last_out  = 1'b0;
    dat_data_out  = '0;
    dat_keep_out  = '0;
    ch0_ready_out = 1'b0;
    ch1_ready_out = 1'b0;

    case (state_q)
      IDLE: begin
        // The request beat itself is not consumed here; it flows in DATA.
        if (req0 || req1) begin
          gnt_d    = pick1;
          remain_d = sel_len;
          addr_d   = sel_addr;
          if (sel_len == 16'd0) begin
            len_err_d = 1'b1;
            state_d   = DRAIN;
          end else begin
            size_d  = burst_size(sel_len);
            state_d = HDR;
          end
        end
      end

      HDR: begin
        hdr_valid_out = 1'b1;
        if (hdr_ready_in) begin
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end

      DATA: begin
        dat_valid_out = g_valid;
        dat_data_out  = g_data;
        dat_keep_out  = g_keep;
        dat_last_out  = g_valid && (at_burst_end || g_last);
        ch0_ready_out = !gnt_q && dat_ready_in;
        ch1_ready_out =  gnt_q && dat_ready_in;
        if (beat_fire) begin
          if (at_burst_end) begin
            remain_d = remain_after;
            addr_d   = addr_q + ADDR_WIDTH'(size_q);
            if (remain_after == 16'd0) begin
              if (g_last) begin
                state_d = IDLE;
              end else begin
                // Length exhausted but the source keeps going: swallow the rest.
                len_err_d = 1'b1;
                state_d   = DRAIN;
              end
            end else if (g_last) begin
              // Source ended on a burst boundary short of its declared length.
              len_err_d = 1'b1;
              state_d   = IDLE;
            end else begin
              size_d  = burst_size(remain_after);
              state_d = HDR;
            end
          end else if (g_last) begin
            len_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      DRAIN: begin
        ch0_ready_out = !gnt_q;
        ch1_ready_out =  gnt_q;
        if (g_valid && g_last) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

`ifdef NWR_SCHED_RR_EN
    prio_d = prio_q ^ ((state_d == IDLE) && ((state_q == DATA) || (state_q == DRAIN)));
`endif
  end

endmodule

// File: tb/tb_srio_nwr_scheduler.sv
// tb/tb_srio_nwr_scheduler.sv - directed bench for srio_nwr_scheduler
module tb_srio_nwr_scheduler;
  localparam int AW = 34;

  logic          clk_srio = 1'b0;
  logic          reset_srio_n;
  logic [63:0]   ch0_data_in, ch1_data_in;
  logic          ch0_valid_in, ch0_first_in, ch0_last_in;
  logic          ch1_valid_in, ch1_first_in, ch1_last_in;
  logic [7:0]    ch0_keep_in, ch1_keep_in;
  logic [15:0]   ch0_length_in, ch1_length_in;
  logic [AW-1:0] ch0_base_addr_in, ch1_base_addr_in;
  logic          ch0_ready_out, ch1_ready_out;
  logic          hdr_valid_out, hdr_ready_in, hdr_ch_out;
  logic [AW-1:0] hdr_addr_out;
  logic [8:0]    hdr_size_out;
  logic [63:0]   dat_data_out;
  logic          dat_valid_out, dat_last_out, dat_ready_in, len_err_out;
  logic [7:0]    dat_keep_out;

  always #5 clk_srio = ~clk_srio;

  srio_nwr_scheduler dut (
    .clk_srio(clk_srio), .reset_srio_n(reset_srio_n),
    .ch0_data_in(ch0_data_in), .ch0_valid_in(ch0_valid_in), .ch0_first_in(ch0_first_in),
    .ch0_last_in(ch0_last_in), .ch0_keep_in(ch0_keep_in), .ch0_length_in(ch0_length_in),
    .ch0_base_addr_in(ch0_base_addr_in), .ch0_ready_out(ch0_ready_out),
    .ch1_data_in(ch1_data_in), .ch1_valid_in(ch1_valid_in), .ch1_first_in(ch1_first_in),
    .ch1_last_in(ch1_last_in), .ch1_keep_in(ch1_keep_in), .ch1_length_in(ch1_length_in),
    .ch1_base_addr_in(ch1_base_addr_in), .ch1_ready_out(ch1_ready_out),
    .hdr_valid_out(hdr_valid_out), .hdr_ready_in(hdr_ready_in), .hdr_addr_out(hdr_addr_out),
    .hdr_size_out(hdr_size_out), .hdr_ch_out(hdr_ch_out),
    .dat_data_out(dat_data_out), .dat_valid_out(dat_valid_out), .dat_keep_out(dat_keep_out),
    .dat_last_out(dat_last_out), .dat_ready_in(dat_ready_in), .len_err_out(len_err_out)
  );

  typedef struct {
    string         name;
    int            ch;
    int            len;
    int            nb;
    logic [AW-1:0] base;
    int            stall;
    bit            tog;
    int            nhdr;
    logic [AW-1:0] a0;
    int            s0;
    logic [AW-1:0] an;
    int            sn;
    int            nlast;
    int            l0;
    int            ln;
    int            fwd;
    bit            err;
  } vec_t;

  vec_t vt[9];
  vec_t v;

  int total = 0;
  int passed = 0;

  logic [AW-1:0] hq_addr[$];
  int            hq_size[$];
  int            hq_ch[$];
  int            lastq[$];
  int            fwd_total;
  bit            data_ok, mirror_ok, stable_ok, stall_done, timed_out;
  bit            prio_model;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
  endtask

  function automatic logic [63:0] pat(input int c, input int i);
    logic [31:0] iv;
    logic [31:0] cv;
    iv = i;
    cv = c;
    return {16'hDA7A, 15'd0, cv[0], iv};
  endfunction

  function automatic vec_t mk(input string name, input int ch, input int len, input int nb,
                              input logic [AW-1:0] base, input int stall, input bit tog,
                              input int nhdr, input logic [AW-1:0] a0, input int s0,
                              input logic [AW-1:0] an, input int sn, input int nlast,
                              input int l0, input int ln, input int fwd, input bit err);
    vec_t r;
    r.name = name; r.ch = ch; r.len = len; r.nb = nb; r.base = base; r.stall = stall;
    r.tog = tog; r.nhdr = nhdr; r.a0 = a0; r.s0 = s0; r.an = an; r.sn = sn;
    r.nlast = nlast; r.l0 = l0; r.ln = ln; r.fwd = fwd; r.err = err;
    return r;
  endfunction

  task automatic drive_ch(input int c, input bit vld, input bit fst, input bit lst,
                          input logic [63:0] d, input logic [15:0] len, input logic [AW-1:0] base);
    if (c == 0) begin
      ch0_valid_in = vld; ch0_first_in = fst; ch0_last_in = lst; ch0_data_in = d;
      ch0_keep_in = 8'hFF; ch0_length_in = len; ch0_base_addr_in = base;
    end else begin
      ch1_valid_in = vld; ch1_first_in = fst; ch1_last_in = lst; ch1_data_in = d;
      ch1_keep_in = 8'hFF; ch1_length_in = len; ch1_base_addr_in = base;
    end
  endtask

  // Acts as both sources and the initiator; records headers, beats and last positions.
  task automatic run_pkts(input int len0, input int nb0, input logic [AW-1:0] b0,
                          input int len1, input int nb1, input logic [AW-1:0] b1,
                          input int stall, input bit tog);
    int idx[2];
    int nb[2];
    int len[2];
    logic [AW-1:0] base[2];
    int stall_left, cyc, dc;
    logic [AW-1:0] s_addr;
    logic [8:0] s_size;
    bit saved;
    nb[0] = nb0; nb[1] = nb1; len[0] = len0; len[1] = len1; base[0] = b0; base[1] = b1;
    idx[0] = 0; idx[1] = 0;
    hq_addr.delete(); hq_size.delete(); hq_ch.delete(); lastq.delete();
    data_ok = 1; mirror_ok = 1; stable_ok = 1; timed_out = 0; fwd_total = 0;
    saved = 0; stall_left = stall; cyc = 0; s_addr = '0; s_size = '0;
    while ((idx[0] < nb[0] || idx[1] < nb[1]) && cyc < 3000) begin
      @(negedge clk_srio);
      for (int c = 0; c < 2; c++)
        drive_ch(c, idx[c] < nb[c], idx[c] == 0, idx[c] == nb[c] - 1, pat(c, idx[c]),
                 16'(len[c]), base[c]);
      hdr_ready_in = !(hdr_valid_out && stall_left > 0);
      dat_ready_in = tog ? cyc[0] : 1'b1;
      #1;
      if (hdr_valid_out && !hdr_ready_in) begin
        if (!saved) begin
          s_addr = hdr_addr_out; s_size = hdr_size_out; saved = 1;
        end else if (hdr_addr_out !== s_addr || hdr_size_out !== s_size) begin
          stable_ok = 0;
        end
        stall_left--;
      end
      if (hdr_valid_out && hdr_ready_in) begin
        if (saved && hq_addr.size() == 0 && (hdr_addr_out !== s_addr || hdr_size_out !== s_size))
          stable_ok = 0;
        hq_addr.push_back(hdr_addr_out);
        hq_size.push_back(int'(hdr_size_out));
        hq_ch.push_back(int'(hdr_ch_out));
      end
      if (dat_valid_out) begin
        if ((ch0_ready_out | ch1_ready_out) !== dat_ready_in || (ch0_ready_out & ch1_ready_out))
          mirror_ok = 0;
        if (dat_ready_in) begin
          dc = dat_data_out[32] ? 1 : 0;
          if (dat_data_out !== pat(dc, idx[dc]) || dat_keep_out !== 8'hFF) data_ok = 0;
          fwd_total++;
          if (dat_last_out) lastq.push_back(fwd_total);
        end
      end
      if (ch0_valid_in && ch0_ready_out) idx[0]++;
      if (ch1_valid_in && ch1_ready_out) idx[1]++;
      cyc++;
    end
    if (cyc >= 3000) timed_out = 1;
    stall_done = (stall_left == 0);
    @(negedge clk_srio);
    drive_ch(0, 0, 0, 0, '0, '0, '0);
    drive_ch(1, 0, 0, 0, '0, '0, '0);
    hdr_ready_in = 1'b1; dat_ready_in = 1'b1;
    repeat (2) @(negedge clk_srio);
    if (nb0 > 0) prio_model = ~prio_model;
    if (nb1 > 0) prio_model = ~prio_model;
  endtask

  function automatic bit first_winner();
`ifdef NWR_SCHED_RR_EN
    return prio_model;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_pair(input string name, input logic [AW-1:0] b0, input logic [AW-1:0] b1);
    bit w;
    w = first_winner();
    run_pkts(8, 1, b0, 8, 1, b1, 0, 0);
    check({name, "_timeout"}, timed_out, 0);
    check({name, "_nhdr"}, hq_ch.size(), 2);
    check({name, "_first_ch"}, (hq_ch.size() > 0) ? hq_ch[0] : -1, w);
    check({name, "_second_ch"}, (hq_ch.size() > 1) ? hq_ch[1] : -1, !w);
    check({name, "_first_addr"}, (hq_addr.size() > 0) ? hq_addr[0] : '1, w ? b1 : b0);
    check({name, "_fwd"}, fwd_total, 2);
    check({name, "_data"}, data_ok, 1);
  endtask

  initial begin
    int n;
    bit got;

    vt[0] = mk("seg600", 0, 600, 75, 34'h1_0000_0000, 5, 0, 3, 34'h1_0000_0000, 256,
               34'h1_0000_0200, 88, 3, 32, 75, 75, 0);
    vt[1] = mk("toggle256", 1, 256, 32, 34'h2_0000_0000, 0, 1, 1, 34'h2_0000_0000, 256,
               34'h2_0000_0000, 256, 1, 32, 32, 32, 0);
    vt[2] = mk("wrap512", 0, 512, 64, 34'h3_FFFF_FF00, 0, 0, 2, 34'h3_FFFF_FF00, 256,
               34'h0_0000_0000, 256, 2, 32, 64, 64, 0);
    vt[3] = mk("single8", 1, 8, 1, 34'h0_0000_1000, 0, 0, 1, 34'h0_0000_1000, 8,
               34'h0_0000_1000, 8, 1, 1, 1, 1, 0);
    vt[4] = mk("odd20", 0, 20, 3, 34'h0_0000_2000, 0, 0, 1, 34'h0_0000_2000, 20,
               34'h0_0000_2000, 20, 1, 3, 3, 3, 0);
    vt[5] = mk("early_last", 0, 64, 4, 34'h0_0000_3000, 0, 0, 1, 34'h0_0000_3000, 64,
               34'h0_0000_3000, 64, 1, 4, 4, 4, 1);
    vt[6] = mk("after_early", 1, 24, 3, 34'h0_0000_4000, 0, 0, 1, 34'h0_0000_4000, 24,
               34'h0_0000_4000, 24, 1, 3, 3, 3, 1);
    vt[7] = mk("late_last", 0, 16, 4, 34'h0_0000_5000, 0, 0, 1, 34'h0_0000_5000, 16,
               34'h0_0000_5000, 16, 1, 2, 2, 2, 1);
    vt[8] = mk("zero_len", 1, 0, 2, 34'h0_0000_6000, 0, 0, 0, '0, 0, '0, 0, 0, 0, 0, 0, 1);

    // Reset with a live request on ch0: everything must read zero.
    reset_srio_n = 1'b0;
    drive_ch(0, 1, 1, 0, pat(0, 0), 16'd8, 34'h1_2345_6789);
    drive_ch(1, 1, 1, 0, pat(1, 0), 16'd8, 34'h0_0000_0040);
    hdr_ready_in = 1'b1; dat_ready_in = 1'b1;
    prio_model = 1'b0;
    repeat (3) @(negedge clk_srio);
    #1;
    check("rst_hdr_valid", hdr_valid_out, 0);
    check("rst_hdr_addr", hdr_addr_out, 0);
    check("rst_hdr_size", hdr_size_out, 0);
    check("rst_hdr_ch", hdr_ch_out, 0);
    check("rst_dat_valid", dat_valid_out, 0);
    check("rst_dat_last", dat_last_out, 0);
    check("rst_dat_data", dat_data_out, 0);
    check("rst_dat_keep", dat_keep_out, 0);
    check("rst_ch0_ready", ch0_ready_out, 0);
    check("rst_ch1_ready", ch1_ready_out, 0);
    check("rst_len_err", len_err_out, 0);
    @(negedge clk_srio);
    drive_ch(0, 0, 0, 0, '0, '0, '0);
    drive_ch(1, 0, 0, 0, '0, '0, '0);
    reset_srio_n = 1'b1;
    @(negedge clk_srio);

    for (int k = 0; k < 9; k++) begin
      v = vt[k];
      if (v.ch == 0) run_pkts(v.len, v.nb, v.base, 0, 0, '0, v.stall, v.tog);
      else           run_pkts(0, 0, '0, v.len, v.nb, v.base, v.stall, v.tog);
      check({v.name, "_timeout"}, timed_out, 0);
      check({v.name, "_nhdr"}, hq_addr.size(), v.nhdr);
      check({v.name, "_fwd"}, fwd_total, v.fwd);
      check({v.name, "_nlast"}, lastq.size(), v.nlast);
      check({v.name, "_len_err"}, len_err_out, v.err);
      check({v.name, "_data"}, data_ok, 1);
      if (v.nhdr > 0) begin
        check({v.name, "_hdr_ch"}, (hq_ch.size() > 0) ? hq_ch[0] : -1, v.ch);
        check({v.name, "_addr_first"}, (hq_addr.size() > 0) ? hq_addr[0] : '1, v.a0);
        check({v.name, "_size_first"}, (hq_size.size() > 0) ? hq_size[0] : -1, v.s0);
        check({v.name, "_addr_final"}, (hq_addr.size() > 0) ? hq_addr[hq_addr.size()-1] : '1, v.an);
        check({v.name, "_size_final"}, (hq_size.size() > 0) ? hq_size[hq_size.size()-1] : -1, v.sn);
      end
      if (v.nlast > 0) begin
        check({v.name, "_last_first"}, (lastq.size() > 0) ? lastq[0] : -1, v.l0);
        check({v.name, "_last_final"}, (lastq.size() > 0) ? lastq[lastq.size()-1] : -1, v.ln);
      end
      if (v.nhdr == 3) begin
        check({v.name, "_addr_mid"}, (hq_addr.size() > 1) ? hq_addr[1] : '1, v.a0 + 34'h100);
        check({v.name, "_last_mid"}, (lastq.size() > 1) ? lastq[1] : -1, 64);
      end
      if (v.stall > 0) begin
        check({v.name, "_hdr_stable"}, stable_ok, 1);
        check({v.name, "_stall_seen"}, stall_done, 1);
      end
      if (v.tog) check({v.name, "_ready_mirror"}, mirror_ok, 1);
    end

    // Reset asserted while the 10th beat of a burst is presented.
    n = 0;
    got = 0;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      @(negedge clk_srio);
      drive_ch(0, 1, n == 0, 0, pat(0, n), 16'd256, 34'h5_0000_0000);
      hdr_ready_in = 1'b1; dat_ready_in = 1'b1;
      #1;
      if (dat_valid_out && n == 9) begin
        reset_srio_n = 1'b0;
        #1;
        got = 1;
      end else if (ch0_valid_in && ch0_ready_out) begin
        n++;
      end
    end
    check("rstmid_reached", got, 1);
    check("rstmid_dat_valid", dat_valid_out, 0);
    check("rstmid_dat_last", dat_last_out, 0);
    check("rstmid_dat_data", dat_data_out, 0);
    check("rstmid_ch0_ready", ch0_ready_out, 0);
    check("rstmid_hdr_valid", hdr_valid_out, 0);
    check("rstmid_hdr_addr", hdr_addr_out, 0);
    check("rstmid_len_err", len_err_out, 0);
    drive_ch(0, 0, 0, 0, '0, '0, '0);
    repeat (2) @(negedge clk_srio);
    reset_srio_n = 1'b1;
    prio_model = 1'b0;
    @(negedge clk_srio);

    run_pkts(0, 0, '0, 16, 2, 34'h6_0000_0040, 0, 0);
    check("post_rst_timeout", timed_out, 0);
    check("post_rst_nhdr", hq_addr.size(), 1);
    check("post_rst_addr", (hq_addr.size() > 0) ? hq_addr[0] : '1, 34'h6_0000_0040);
    check("post_rst_size", (hq_size.size() > 0) ? hq_size[0] : -1, 16);
    check("post_rst_ch", (hq_ch.size() > 0) ? hq_ch[0] : -1, 1);
    check("post_rst_fwd", fwd_total, 2);
    check("post_rst_last", (lastq.size() > 0) ? lastq[0] : -1, 2);
    check("post_rst_len_err", len_err_out, 0);

    // Simultaneous requests, separated by one lone packet so the tie-breaker shifts.
    check_pair("pair_a", 34'h7_0000_0000, 34'h7_0000_1000);
    run_pkts(8, 1, 34'h7_0000_2000, 0, 0, '0, 0, 0);
    check("lone_fwd", fwd_total, 1);
    check_pair("pair_b", 34'h7_0000_3000, 34'h7_0000_4000);
    check("final_len_err", len_err_out, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
